raster_cmd_queue: RTL and testbench
===================================

RASTER_CMD_QUEUE -- requirements
Module: raster_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..64.
REQ-002 Parameter CMD_W, default 3, raster command code width.
REQ-003 Parameter COLOUR_W, default 3, colour width.
REQ-004 Parameter COORD_W, default 8, width of each coordinate.
REQ-005 clk  input  1  system clock, 50MHz; all state changes on rising edge.
REQ-006 rst_async  input  1  one clock; reset is asynchronous and active-low: low forces reset state immediately, release is sampled on clk.
REQ-007 push_valid  input  1  CPU offers one command this cycle.
REQ-008 push_ready  output  1  queue can accept a push this cycle.
REQ-009 push_command  input  CMD_W  command code to enqueue.
REQ-010 push_colour  input  COLOUR_W  colour to enqueue.
REQ-011 push_x0, push_y0, push_x1, push_y1  input  COORD_W each  coordinates to enqueue.
REQ-012 flush  input  1  discard all queued, not-yet-issued entries.
REQ-013 gpu_execute_request  output  1  rasterizer command request.
REQ-014 gpu_command, gpu_colour, gpu_x0, gpu_y0, gpu_x1, gpu_y1  output  widths as push side  operands of the in-flight command.
REQ-015 gpu_done  input  1  one-cycle pulse from the rasterizer: in-flight command finished.
REQ-016 count  output  $clog2(DEPTH)+1  queued entries, excluding the in-flight one.
REQ-017 overflow  output  1  sticky: a push was attempted while push_ready was low.

Function
REQ-018 Storage SHALL be a circular buffer, DEPTH entries, read/write pointers wrapping modulo DEPTH.
REQ-019 push_ready SHALL equal (count < DEPTH), decoded from registered state only; it does not depend on same-cycle pop or flush.
REQ-020 A push SHALL occur when push_valid and push_ready are both high; the entry is written at the write pointer, which then increments.
REQ-021 FSM states SHALL be IDLE, ISSUE, GAP.
REQ-022 IDLE: gpu_execute_request low; when count>0, go to ISSUE next cycle, load the head entry into the output operand registers, pop it (read pointer +1, count -1).
REQ-023 ISSUE: gpu_execute_request high; operand outputs held stable; on gpu_done go to GAP.
REQ-024 GAP: one cycle with gpu_execute_request low; then go to IDLE. Back-to-back commands are therefore separated by at least 2 low cycles.
REQ-025 gpu_done outside ISSUE SHALL be ignored.
REQ-026 Latency: a push into an empty queue in IDLE at cycle N SHALL give gpu_execute_request high at cycle N+2.
REQ-027 A push and a pop in the same cycle SHALL leave count unchanged, and both pointers advance.
REQ-028 flush SHALL set count to 0 and read pointer to write pointer next cycle; it SHALL NOT affect an in-flight command (ISSUE/GAP continue normally), and SHALL clear overflow.
REQ-029 flush together with push_valid: flush wins and the pushed entry is discarded.
REQ-030 flush together with an IDLE pop: no pop, FSM stays IDLE.
REQ-031 overflow SHALL set on push_valid && !push_ready and hold until flush or reset; a rejected push SHALL NOT alter storage, pointers or count.
REQ-032 Output operand registers SHALL change only when entering ISSUE.

Reset
REQ-033 On rst_async low: FSM=IDLE; pointers, count, overflow=0; gpu_execute_request=0; all gpu operand outputs=0; push_ready=1. Storage contents need not reset.
REQ-034 Reset asserted mid-ISSUE SHALL drop gpu_execute_request immediately (asynchronously) and discard all entries.

Verification
REQ-035 Single push {cmd=2, colour=5, x0=10, y0=10, x1=100, y1=100} into an empty queue -> gpu_execute_request rises 2 cycles later with exactly those operands; it holds until gpu_done, then is low for the GAP cycle; count returns to 0.
REQ-036 DEPTH=4: stall gpu_done and push 6 commands (the first goes in flight) -> count=4, push_ready=0 after the 5th push, 6th push rejected, overflow=1; releasing gpu_done issues the remaining commands in FIFO order.
REQ-037 Pointer wrap: 10 push/complete cycles with DEPTH=4 -> all 10 commands issued in order with correct operands, and count never exceeds 1.
REQ-038 Simultaneous push and IDLE pop with count=2 -> count stays 2, and the head issued is the oldest entry.
REQ-039 flush during ISSUE with 3 queued entries -> count=0 and overflow=0 next cycle; the in-flight command completes on gpu_done, then the FSM stays IDLE with no further requests.
REQ-040 rst_async pulsed low during ISSUE -> gpu_execute_request=0 in the same cycle, count=0, push_ready=1; after release, a new push issues normally.

Source files
------------

// File: rtl/raster_cmd_queue.sv
// Raster command queue: buffers CPU draw commands in a circular FIFO and issues
// them one at a time to the rasterizer, with a mandatory idle gap between commands.
//
// Ports:
//   clk, rst_async        clock and asynchronous active-low reset
//   push_*                CPU enqueue side (valid/ready handshake plus operands)
//   flush                 discard every queued entry that has not yet been issued
//   gpu_execute_request   high while a command is in flight
//   gpu_* operands        operands of the in-flight command
//   gpu_done              one-cycle completion pulse from the rasterizer
//   count                 number of queued entries, excluding the in-flight one
//   overflow              sticky flag: a push was attempted while the queue was full
module raster_cmd_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CMD_W    = 3,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned COORD_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_async,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [CMD_W-1:0]           push_command,
  input  logic [COLOUR_W-1:0]        push_colour,
  input  logic [COORD_W-1:0]         push_x0,
  input  logic [COORD_W-1:0]         push_y0,
  input  logic [COORD_W-1:0]         push_x1,
  input  logic [COORD_W-1:0]         push_y1,
  input  logic                       flush,
  output logic                       gpu_execute_request,
  output logic [CMD_W-1:0]           gpu_command,
  output logic [COLOUR_W-1:0]        gpu_colour,
  output logic [COORD_W-1:0]         gpu_x0,
  output logic [COORD_W-1:0]         gpu_y0,
  output logic [COORD_W-1:0]         gpu_x1,
  output logic [COORD_W-1:0]         gpu_y1,
  input  logic                       gpu_done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = CMD_W + COLOUR_W + 4 * COORD_W;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [EntW-1:0]   op_q, op_d;
  logic [EntW-1:0]   mem_q [DEPTH];

  logic [EntW-1:0]   push_entry;
  logic              push_fire;
  logic              pop;

  assign push_entry = {push_command, push_colour, push_x0, push_y0, push_x1, push_y1};

  // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign push_ready = (count_q < CntW'(DEPTH));
  // Flush wins over both a push and an IDLE pop in the same cycle.
  assign push_fire  = push_valid & push_ready & ~flush;
  assign pop        = (state_q == StIdle) & (count_q != '0) & ~flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pop) state_d = StIssue;
      StIssue: if (gpu_done) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    op_d       = op_q;

    if (push_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);

    if (flush) begin
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_fire, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (push_valid && !push_ready) overflow_d = 1'b1;
    end

    // Operands are captured only on the IDLE->ISSUE transition.
    if (pop) op_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      op_q       <= op_d;
    end
  end

  // Storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_entry;
  end

  assign gpu_execute_request = (state_q == StIssue);
  assign {gpu_command, gpu_colour, gpu_x0, gpu_y0, gpu_x1, gpu_y1} = op_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_raster_cmd_queue.sv
module tb_raster_cmd_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CMD_W    = 3;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned COORD_W  = 8;
  localparam int unsigned EntW     = CMD_W + COLOUR_W + 4 * COORD_W;

  logic                clk;
  logic                rst_async;
  logic                push_valid;
  logic                push_ready;
  logic [CMD_W-1:0]    push_command;
  logic [COLOUR_W-1:0] push_colour;
  logic [COORD_W-1:0]  push_x0, push_y0, push_x1, push_y1;
  logic                flush;
  logic                gpu_execute_request;
  logic [CMD_W-1:0]    gpu_command;
  logic [COLOUR_W-1:0] gpu_colour;
  logic [COORD_W-1:0]  gpu_x0, gpu_y0, gpu_x1, gpu_y1;
  logic                gpu_done;
  logic [2:0]          count;
  logic                overflow;

  raster_cmd_queue #(
    .DEPTH    (DEPTH),
    .CMD_W    (CMD_W),
    .COLOUR_W (COLOUR_W),
    .COORD_W  (COORD_W)
  ) dut (
    .clk                 (clk),
    .rst_async           (rst_async),
    .push_valid          (push_valid),
    .push_ready          (push_ready),
    .push_command        (push_command),
    .push_colour         (push_colour),
    .push_x0             (push_x0),
    .push_y0             (push_y0),
    .push_x1             (push_x1),
    .push_y1             (push_y1),
    .flush               (flush),
    .gpu_execute_request (gpu_execute_request),
    .gpu_command         (gpu_command),
    .gpu_colour          (gpu_colour),
    .gpu_x0              (gpu_x0),
    .gpu_y0              (gpu_y0),
    .gpu_x1              (gpu_x1),
    .gpu_y1              (gpu_y1),
    .gpu_done            (gpu_done),
    .count               (count),
    .overflow            (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [EntW-1:0] exp_q [$];
  logic [EntW-1:0] observed;
  logic [EntW-1:0] cur_op;
  logic [EntW-1:0] exp_ent;
  logic            req_prev = 1'b0;

  assign observed = {gpu_command, gpu_colour, gpu_x0, gpu_y0, gpu_x1, gpu_y1};

  // Scoreboard monitor: each new request must carry the oldest expected command,
  // and operands must stay stable while the request is held.
  always @(negedge clk) begin
    if (!rst_async) begin
      req_prev = 1'b0;
    end else begin
      if (gpu_execute_request && !req_prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL issue_unexpected: got %h required no request", observed);
        end else begin
          exp_ent = exp_q.pop_front();
          if (observed !== exp_ent) begin
            fails++;
            $display("FAIL issue_order: got %h required %h", observed, exp_ent);
          end
        end
        cur_op = observed;
      end else if (gpu_execute_request) begin
        tests++;
        if (observed !== cur_op) begin
          fails++;
          $display("FAIL operand_stable: got %h required %h", observed, cur_op);
        end
      end
      req_prev = gpu_execute_request;
    end
  end

  function automatic logic [EntW-1:0] mk(input int i);
    return {3'(i), 3'(i + 1), 8'(i * 7), 8'(i * 3 + 1), 8'(255 - i), 8'(i + 40)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [EntW-1:0] e, input bit expect_issue);
    push_valid = 1'b1;
    {push_command, push_colour, push_x0, push_y0, push_x1, push_y1} = e;
    tick();
    push_valid = 1'b0;
    if (expect_issue) exp_q.push_back(e);
  endtask

  // Wait (bounded) for a request, hold it a cycle, then pulse gpu_done; returns in GAP.
  task automatic complete();
    int waited = 0;
    while (!gpu_execute_request && waited < 40) begin
      tick();
      waited++;
    end
    tests++;
    if (!gpu_execute_request) begin
      fails++;
      $display("FAIL complete_timeout: got request=%b required 1", gpu_execute_request);
    end else begin
      tick();
      gpu_done = 1'b1;
      tick();
      gpu_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_async = 1'b0;
    #25;
    tests++; if (gpu_execute_request !== 1'b0) begin fails++;
      $display("FAIL reset_req: got %b required 0", gpu_execute_request); end
    tests++; if (count !== 3'd0) begin fails++;
      $display("FAIL reset_count: got %0d required 0", count); end
    tests++; if (push_ready !== 1'b1) begin fails++;
      $display("FAIL reset_ready: got %b required 1", push_ready); end
    tests++; if (overflow !== 1'b0) begin fails++;
      $display("FAIL reset_overflow: got %b required 0", overflow); end
    tests++; if (observed !== '0) begin fails++;
      $display("FAIL reset_operands: got %h required 0", observed); end
    tick();
    rst_async = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [EntW-1:0] e;
    e = {3'd2, 3'd5, 8'd10, 8'd10, 8'd100, 8'd100};
    push(e, 1'b1);
    tests++; if (gpu_execute_request !== 1'b0 || count !== 3'd1) begin fails++;
      $display("FAIL single_n1: got req=%b count=%0d required req=0 count=1",
               gpu_execute_request, count); end
    tick();
    tests++; if (gpu_execute_request !== 1'b1 || observed !== e || count !== 3'd0) begin fails++;
      $display("FAIL single_n2: got req=%b ops=%h count=%0d required req=1 ops=%h count=0",
               gpu_execute_request, observed, count, e); end
    tick();
    tick();
    tests++; if (gpu_execute_request !== 1'b1) begin fails++;
      $display("FAIL single_hold: got %b required 1", gpu_execute_request); end
    gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    tests++; if (gpu_execute_request !== 1'b0) begin fails++;
      $display("FAIL single_gap: got %b required 0", gpu_execute_request); end
    tick();
    tests++; if (gpu_execute_request !== 1'b0 || count !== 3'd0) begin fails++;
      $display("FAIL single_idle: got req=%b count=%0d required req=0 count=0",
               gpu_execute_request, count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) push(mk(i), 1'b1);
    tests++; if (count !== 3'd4 || push_ready !== 1'b0 || overflow !== 1'b0) begin fails++;
      $display("FAIL full_state: got count=%0d ready=%b ovf=%b required 4 0 0",
               count, push_ready, overflow); end
    push(mk(5), 1'b0);
    tests++; if (overflow !== 1'b1 || count !== 3'd4) begin fails++;
      $display("FAIL overflow_set: got ovf=%b count=%0d required 1 4", overflow, count); end
    complete();
    tests++; if (gpu_execute_request !== 1'b0) begin fails++;
      $display("FAIL b2b_gap: got %b required 0", gpu_execute_request); end
    tick();
    tests++; if (gpu_execute_request !== 1'b0) begin fails++;
      $display("FAIL b2b_idle: got %b required 0", gpu_execute_request); end
    tick();
    tests++; if (gpu_execute_request !== 1'b1 || count !== 3'd3) begin fails++;
      $display("FAIL b2b_next: got req=%b count=%0d required 1 3", gpu_execute_request, count); end
    for (int i = 0; i < 4; i++) complete();
    tick();
    tick();
    tests++; if (count !== 3'd0 || exp_q.size() != 0 || overflow !== 1'b1) begin fails++;
      $display("FAIL overflow_drain: got count=%0d pending=%0d ovf=%b required 0 0 1",
               count, exp_q.size(), overflow); end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    push(mk(20), 1'b1);
    push(mk(21), 1'b0);
    push(mk(22), 1'b0);
    push(mk(23), 1'b0);
    tests++; if (count !== 3'd3 || gpu_execute_request !== 1'b1) begin fails++;
      $display("FAIL flush_pre: got count=%0d req=%b required 3 1", count, gpu_execute_request); end
    flush = 1'b1;
    push(mk(24), 1'b0);
    flush = 1'b0;
    tests++; if (count !== 3'd0 || overflow !== 1'b0 || push_ready !== 1'b1) begin fails++;
      $display("FAIL flush_clear: got count=%0d ovf=%b ready=%b required 0 0 1",
               count, overflow, push_ready); end
    tests++; if (gpu_execute_request !== 1'b1 || observed !== mk(20)) begin fails++;
      $display("FAIL flush_inflight: got req=%b ops=%h required 1 %h",
               gpu_execute_request, observed, mk(20)); end
    complete();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gpu_execute_request) seen = 1'b1;
    end
    tests++; if (seen) begin fails++;
      $display("FAIL flush_quiet: got request after flush required none"); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      push(mk(30 + i), 1'b1);
      tests++; if (count > 3'd1) begin fails++;
        $display("FAIL wrap_count: got %0d required <=1", count); end
      complete();
    end
  endtask

  task automatic test_back_to_back();
    push(mk(50), 1'b1);
    push(mk(51), 1'b1);
    push(mk(52), 1'b1);
    tests++; if (count !== 3'd2 || gpu_execute_request !== 1'b1) begin fails++;
      $display("FAIL simul_pre: got count=%0d req=%b required 2 1", count, gpu_execute_request); end
    tick();
    gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    tick();
    tests++; if (count !== 3'd2 || gpu_execute_request !== 1'b0) begin fails++;
      $display("FAIL simul_idle: got count=%0d req=%b required 2 0", count, gpu_execute_request); end
    push(mk(53), 1'b1);
    tests++; if (count !== 3'd2 || gpu_execute_request !== 1'b1 || observed !== mk(51)) begin
      fails++;
      $display("FAIL simul_pushpop: got count=%0d req=%b ops=%h required 2 1 %h",
               count, gpu_execute_request, observed, mk(51)); end
    for (int i = 0; i < 3; i++) complete();
  endtask

  task automatic test_reset_mid();
    push(mk(60), 1'b1);
    push(mk(61), 1'b0);
    tests++; if (gpu_execute_request !== 1'b1) begin fails++;
      $display("FAIL rstmid_pre: got %b required 1", gpu_execute_request); end
    rst_async = 1'b0;
    #1;
    exp_q.delete();
    tests++; if (gpu_execute_request !== 1'b0 || count !== 3'd0 || push_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_async: got req=%b count=%0d ready=%b required 0 0 1",
               gpu_execute_request, count, push_ready); end
    tests++; if (observed !== '0) begin fails++;
      $display("FAIL rstmid_ops: got %h required 0", observed); end
    tick();
    tick();
    rst_async = 1'b1;
    tick();
    push(mk(62), 1'b1);
    complete();
    tick();
    tick();
    tests++; if (count !== 3'd0 || gpu_execute_request !== 1'b0) begin fails++;
      $display("FAIL rstmid_after: got count=%0d req=%b required 0 0", count, gpu_execute_request); end
  endtask

  initial begin
    rst_async    = 1'b0;
    push_valid   = 1'b0;
    flush        = 1'b0;
    gpu_done     = 1'b0;
    push_command = '0;
    push_colour  = '0;
    push_x0      = '0;
    push_y0      = '0;
    push_x1      = '0;
    push_y1      = '0;

    test_reset();
    test_single();
    test_overflow();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_reset_mid();

    tick();
    tick();
    tick();
    tests++; if (exp_q.size() != 0) begin fails++;
      $display("FAIL scoreboard_empty: got %0d pending required 0", exp_q.size()); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "timeout");
  end

endmodule
